// File: rtl/regfile_issue_ctrl.sv
// Issue/operand-fetch stage in front of a 16x32 register file with a busy scoreboard.
// Optional WB_BYPASS_EN lets a same-cycle writeback release hazard and full checks.
module regfile_issue_ctrl #(
   parameter int MAX_PENDING = 4,
   parameter int DW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_rs1,
   input  logic [3:0]    in_rs2,
   input  logic [3:0]    in_rd,
   input  logic          in_wen,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic [3:0]    out_rd,
   output logic          out_wen,
   input  logic          wb_valid,
   input  logic [3:0]    wb_sel,
   input  logic [DW-1:0] wb_data,
   output logic          EN,
   output logic          RD,
   output logic          WR,
   output logic [3:0]    sel_o1,
   output logic [3:0]    sel_o2,
   output logic [3:0]    sel_i1,
   output logic [DW-1:0] Ip1,
   input  logic [DW-1:0] Op1,
   input  logic [DW-1:0] Op2,
   output logic          wb_err,
   output logic [3:0]    pending_cnt
);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   state_t        state_q, state_d;
   logic [15:0]   busy_q, busy_d, busy_eff;
   logic [15:0]   clr_vec, set_vec;
   logic [3:0]    cnt_q, cnt_d, cnt_eff;
   logic [3:0]    rs1_q, rs2_q, rd_q;
   logic          wen_q;
   logic [DW-1:0] a_q, a_d, b_q, b_d;
   logic          err_q, err_d;
   logic          hazard, full, accept, wb_hit, inc;

   assign clr_vec = wb_valid ? (16'd1 << wb_sel) : 16'd0;
   assign wb_hit  = wb_valid & busy_q[wb_sel];

`ifdef WB_BYPASS_EN
   assign busy_eff = busy_q & ~clr_vec;
   assign cnt_eff  = cnt_q - {3'd0, wb_hit};
`else
   assign busy_eff = busy_q;
   assign cnt_eff  = cnt_q;
`endif

   assign hazard = busy_eff[in_rs1] | busy_eff[in_rs2]
                 | (in_wen & busy_eff[in_rd]);
   assign full   = (cnt_eff == 4'(MAX_PENDING)) & in_wen;

   // Gated by rst_n so nothing is offered while reset is held.
   assign in_ready = rst_n & (state_q == IDLE) & ~hazard & ~full;
   assign accept   = in_valid & in_ready;
   assign inc      = accept & in_wen;
   assign set_vec  = inc ? (16'd1 << in_rd) : 16'd0;

   // Set is applied after clear so a same-edge set/clear leaves the bit busy.
   assign busy_d = (busy_q & ~clr_vec) | set_vec;
   assign cnt_d  = cnt_q + {3'd0, inc} - {3'd0, wb_hit};
   assign err_d  = err_q | (wb_valid & ~busy_q[wb_sel]);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         IDLE: if (accept) state_d = READ;
         READ: begin
            state_d = HOLD;
            a_d     = Op1;
            b_d     = Op2;
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= '0;
         cnt_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         if (accept) begin
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            rd_q  <= in_rd;
            wen_q <= in_wen;
         end
      end
   end

   assign out_valid   = (state_q == HOLD);
   assign out_a       = a_q;
   assign out_b       = b_q;
   assign out_rd      = rd_q;
   assign out_wen     = wen_q;
   assign EN          = rst_n;
   assign RD          = (state_q == READ);
   assign sel_o1      = rs1_q;
   assign sel_o2      = rs2_q;
   assign WR          = wb_valid;
   assign sel_i1      = wb_sel;
   assign Ip1         = wb_data;
   assign wb_err      = err_q;
   assign pending_cnt = cnt_q;

endmodule

// File: doc/regfile_issue_ctrl.md
Name: regfile_issue_ctrl

Overview:
- Issue/operand-fetch stage directly upstream of the 16x32 register file.
- Accepts decoded instructions (rs1, rs2, rd) over a valid/ready handshake.
- Checks a 16-entry busy scoreboard for RAW/WAW hazards, drives the register file read selects, captures Op1/Op2 and presents them to the execute stage.
- Also forwards the execute-stage writeback onto the register file write port and clears the scoreboard.

Parameters:
- MAX_PENDING, 4, maximum outstanding writes (issued, not yet written back); range 1..15.
- DW, 32, data width; must match the register file.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid&in_ready
- in_rs1  in  4  source register 1
- in_rs2  in  4  source register 2
- in_rd  in  4  destination register
- in_wen  in  1  instruction writes rd
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_a  out  DW  captured Op1
- out_b  out  DW  captured Op2
- out_rd  out  4  destination tag
- out_wen  out  1  destination write flag
- wb_valid  in  1  writeback request
- wb_sel  in  4  writeback register
- wb_data  in  DW  writeback data
- EN  out  1  register file enable
- RD  out  1  register file read strobe
- WR  out  1  register file write strobe
- sel_o1  out  4  read select 1
- sel_o2  out  4  read select 2
- sel_i1  out  4  write select
- Ip1  out  DW  write data
- Op1  in  DW  register file read data 1
- Op2  in  DW  register file read data 2
- wb_err  out  1  sticky: writeback to non-busy register
- pending_cnt  out  4  outstanding write count

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, scoreboard=0, pending_cnt=0.
  - All outputs 0, except EN=1 once rst_n=1.
- Write port is combinational pass-through: WR=wb_valid, sel_i1=wb_sel, Ip1=wb_data.
- Scoreboard bit b is cleared on the clock edge where wb_valid & wb_sel==b.
- hazard = busy[rs1] | busy[rs2] | (in_wen & busy[rd]).
- full = (pending_cnt==MAX_PENDING) & in_wen.
- FSM states:
  - IDLE: in_ready = ~hazard & ~full.
    - On accept: latch rs1/rs2/rd/wen; if wen, set busy[rd] and pending_cnt+1; go to READ.
  - READ (exactly 1 cycle): RD=1, sel_o1=rs1, sel_o2=rs2.
    - At the end of the cycle, capture Op1 into out_a and Op2 into out_b; go to HOLD.
  - HOLD: out_valid=1; out_a/out_b/out_rd/out_wen are held stable.
    - On out_ready, go to IDLE.
- Latency: accept at edge N → RD high in cycle N+1 → out_valid from cycle N+2. Maximum throughput is 1 instruction per 3 cycles.
- sel_o1/sel_o2 hold their last value outside READ. RD=0 outside READ.
- Writeback decrements pending_cnt only if the target was busy. Otherwise the count is unchanged and wb_err is set (cleared only by reset).
- Same-edge set and clear of the same bit: set wins, pending_cnt unchanged.
- Same-edge issue with wen and writeback to a different busy register: pending_cnt unchanged.
- rd=rs1 or rd=rs2 is legal; the source is read before busy is set, so the old value is used.
- in_* fields are ignored when in_ready=0.
- Reset mid-operation: pending instruction dropped, scoreboard cleared, out_valid deasserts immediately.

Optional Feature:
- WB_BYPASS_EN defined:
  - Hazard and full are evaluated against the scoreboard with the current-cycle writeback already applied.
  - A writeback to a blocking register permits accept in the same cycle.
  - If that writeback makes the register file write and read coincide, the same-edge write-then-read ordering of the register file supplies the new value.
- Undefined:
  - The scoreboard clear is visible from the next cycle.
  - Exactly one extra stall cycle.

Test Plan:
- Reset, then issue rs1=0,rs2=1,rd=2,wen=1 with r0=0xABCDEFAB, r1=0x01234567 → RD high at N+1 with sel_o1=0, sel_o2=1; out_valid at N+2 with out_a=0xABCDEFAB, out_b=0x01234567, out_rd=2; pending_cnt=1.
- With r2 busy, issue rs1=2 → in_ready=0. wb_valid, wb_sel=2, wb_data=0x55 → WR=1, sel_i1=2, Ip1=0x55. Accept follows in the same cycle with WB_BYPASS_EN, next cycle without. out_a=0x55.
- Issue 4 writing instructions to r3..r6 without writeback (MAX_PENDING=4) → pending_cnt=4. Writing instruction stalls; non-writing instruction (wen=0) to free sources is accepted.
- Writeback to r9 while not busy → wb_err=1 sticky, pending_cnt unchanged, WR=1 still.
- Hold out_ready=0 for 5 cycles in HOLD → out_a/out_b stable, in_ready=0. Assert rst_n=0 mid-HOLD → out_valid=0, pending_cnt=0, busy cleared asynchronously.
